wake_io_ctrl: RTL and testbench

WAKE_IO_CTRL -- requirements
Module: wake_io_ctrl

---
 rtl/wake_io_pkg.sv | 20 ++
 rtl/wake_io_ctrl_if.sv | 23 ++
 rtl/sync_2ff.sv | 19 +
 rtl/wake_io_ctrl.sv | 142 ++++++++++++++
 tb/tb_wake_io_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wake_io_pkg.sv
// Shared definitions for the wake I/O controller: register map, CTRL bit
// positions and FSM state encoding.
package wake_io_pkg;

   localparam logic [1:0] ADR_CTRL    = 2'd0;
   localparam logic [1:0] ADR_STRETCH = 2'd1;
   localparam logic [1:0] ADR_STATUS  = 2'd2;
   localparam logic [1:0] ADR_COUNT   = 2'd3;

   localparam int CTRL_ENABLE   = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_VAD_GATE = 2;
   localparam int CTRL_MASK_LSB = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } wake_state_e;

endpackage

// File: rtl/wake_io_ctrl_if.sv
// Wishbone classic slave bus for the wake I/O controller.
// Handshake: the master raises stb&cyc with adr/we/sel/dat stable and holds
// them until it samples ack high at a clock edge; ack is the only "ready".
interface wake_io_ctrl_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; q lags d by two clocks.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/wake_io_ctrl.sv
// Wake I/O controller: edge-detected, masked wake sources stretch a wake pad
// pulse, with sticky status, a saturating event counter and a level interrupt.
module wake_io_ctrl
   import wake_io_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int STRETCH_W = 16,
   parameter int CNT_W     = 16
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   wake_io_ctrl_if.slave     bus,
   input  logic [NUM_CH-1:0] wake_i,
   input  logic              vad_pad_i,
   output logic              wake_pad_o,
   output logic              irq_o,
   output wake_state_e       dbg_state
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                 enable, irq_en, vad_gate;
   logic [NUM_CH-1:0]    mask, status, wake_q, ev, status_clr;
   logic [STRETCH_W-1:0] stretch, hold;
   logic [CNT_W-1:0]     count;
   logic                 ack, vad_sync, any_ev, wr;
   logic [1:0]           idx;
   logic [31:0]          rdata;
   wake_state_e          state;
   logic                 unused_bits;

   sync_2ff u_vad_sync (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (vad_pad_i),
      .q   (vad_sync)
   );

   assign idx         = bus.wbs_adr_i[3:2];
   assign wr          = ack & bus.wbs_stb_i & bus.wbs_cyc_i & bus.wbs_we_i;
   assign unused_bits = ^{bus.wbs_adr_i, bus.wbs_dat_i, bus.wbs_sel_i};

   // wake_q resets low, but CTRL.enable also resets low, so a wake line that
   // is already high at reset release cannot produce an event.
   assign ev     = wake_i & ~wake_q & mask & {NUM_CH{enable & (~vad_gate | vad_sync)}};
   assign any_ev = |ev;
   assign status_clr = (wr && idx == ADR_STATUS) ? bus.wbs_dat_i[NUM_CH-1:0] : '0;

   always_comb begin
      rdata = '0;
      case (idx)
         ADR_CTRL: begin
            rdata[CTRL_ENABLE]              = enable;
            rdata[CTRL_IRQ_EN]              = irq_en;
            rdata[CTRL_VAD_GATE]            = vad_gate;
            rdata[CTRL_MASK_LSB +: NUM_CH]  = mask;
         end
         ADR_STRETCH: rdata[STRETCH_W-1:0] = stretch;
         ADR_STATUS:  rdata[NUM_CH-1:0]    = status;
         default:     rdata[CNT_W-1:0]     = count;
      endcase
   end

   assign bus.wbs_ack_o = ack;
   assign bus.wbs_dat_o = ack ? rdata : '0;
   assign dbg_state     = state;

   // Bus side: ack never repeats back-to-back; writes land at the end of the ack cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack      <= 1'b0;
         enable   <= 1'b0;
         irq_en   <= 1'b0;
         vad_gate <= 1'b0;
         mask     <= '0;
         stretch  <= '0;
      end else begin
         ack <= bus.wbs_stb_i & bus.wbs_cyc_i & ~ack;
         if (wr && idx == ADR_CTRL) begin
            if (bus.wbs_sel_i[0]) begin
               enable   <= bus.wbs_dat_i[CTRL_ENABLE];
               irq_en   <= bus.wbs_dat_i[CTRL_IRQ_EN];
               vad_gate <= bus.wbs_dat_i[CTRL_VAD_GATE];
            end
            if (bus.wbs_sel_i[1])
               mask <= bus.wbs_dat_i[CTRL_MASK_LSB +: NUM_CH];
         end
         if (wr && idx == ADR_STRETCH) begin
            for (int i = 0; i < STRETCH_W; i++)
               if (bus.wbs_sel_i[i/8]) stretch[i] <= bus.wbs_dat_i[i];
         end
      end
   end

   // Event bookkeeping: a new event always beats a simultaneous clear.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wake_q <= '0;
         status <= '0;
         count  <= '0;
         irq_o  <= 1'b0;
      end else begin
         wake_q <= wake_i;
         status <= (status & ~status_clr) | ev;
         if (wr && idx == ADR_COUNT)
            count <= any_ev ? CNT_W'(1) : '0;
         else if (any_ev && count != CNT_MAX)
            count <= count + CNT_W'(1);
         irq_o <= irq_en & (|status);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= ST_IDLE;
         hold       <= '0;
         wake_pad_o <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_ev) begin
                  state      <= ST_HOLD;
                  hold       <= stretch;
                  wake_pad_o <= 1'b1;
               end
            end
            default: begin
               if (!enable) begin
                  state      <= ST_IDLE;
                  wake_pad_o <= 1'b0;
               end else if (any_ev) begin
                  hold <= stretch;
               end else if (hold == '0) begin
                  state      <= ST_IDLE;
                  wake_pad_o <= 1'b0;
               end else begin
                  hold <= hold - STRETCH_W'(1);
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wake_io_ctrl.sv
// Directed testbench for wake_io_ctrl: register table, stretch/retrigger,
// vad gating, W1C/irq, counter saturation and reset in mid-HOLD.
module tb_wake_io_ctrl;
   import wake_io_pkg::*;

   typedef struct {
      logic [1:0]  idx;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] exp_rd;
      string       name;
   } reg_vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  wake = '0;
   logic        vad_pad = 1'b0;
   logic        wake_pad, irq;
   wake_state_e dbg_state;
   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   reg_vec_t    vecs[10];

   wake_io_ctrl_if bus ();

   wake_io_ctrl #(.NUM_CH(4), .STRETCH_W(16), .CNT_W(4)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .bus        (bus),
      .wake_i     (wake),
      .vad_pad_i  (vad_pad),
      .wake_pad_o (wake_pad),
      .irq_o      (irq),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wb_idle();
      bus.wbs_stb_i = 1'b0;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = '0;
      bus.wbs_dat_i = '0;
      bus.wbs_adr_i = '0;
   endtask

   // ack_wake, when non-zero, is driven onto wake_i during the ack cycle.
   task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] d,
                          input logic [3:0] sel, input logic [3:0] ack_wake,
                          output logic [31:0] rd);
      logic ok;
      ok = 1'b0;
      rd = '0;
      bus.wbs_adr_i = {28'hA5A5A5A, idx, 2'b01};
      bus.wbs_dat_i = d;
      bus.wbs_sel_i = sel;
      bus.wbs_we_i  = we;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_cyc_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.wbs_ack_o) begin
            ok = 1'b1;
            rd = bus.wbs_dat_o;
            break;
         end
      end
      if (!ok) check("wb_ack_timeout", 32'(ok), 32'd1);
      if (ack_wake != '0) wake = ack_wake;
      tick();
      check("ack_one_cycle", 32'(bus.wbs_ack_o), 32'd0);
      wb_idle();
      if (ack_wake != '0) wake = '0;
   endtask

   task automatic wb_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] sel);
      logic [31:0] junk;
      wb_xfer(1'b1, idx, d, sel, 4'h0, junk);
   endtask

   task automatic expect_read(input logic [1:0] idx, input logic [31:0] exp, input string name);
      logic [31:0] rd;
      exp_q.push_back(exp);
      wb_xfer(1'b0, idx, 32'h0, 4'hF, 4'h0, rd);
      check(name, rd, exp_q.pop_front());
   endtask

   // Edges on channels ch at relative cycles ea and eb; pad must be high for
   // cycles first_hi..last_hi relative to the first edge cycle.
   task automatic pulse_run(input logic [3:0] ch, input int ea, input int eb, input int ncyc,
                            input int first_hi, input int last_hi, input string name);
      for (int c = 0; c < ncyc; c++)
         exp_q.push_back(32'((c + 1 >= first_hi) && (c + 1 <= last_hi)));
      for (int c = 0; c < ncyc; c++) begin
         wake = (c == ea || c == eb) ? ch : 4'h0;
         tick();
         check(name, 32'(wake_pad), exp_q.pop_front());
      end
      wake = '0;
   endtask

   initial begin
      vecs[0] = '{ADR_CTRL,    32'hFFFF_FFFF, 4'hF, 32'h0000_0F07, "ctrl_all"};
      vecs[1] = '{ADR_CTRL,    32'h0000_0000, 4'h1, 32'h0000_0F00, "ctrl_sel0"};
      vecs[2] = '{ADR_CTRL,    32'h0000_0000, 4'h2, 32'h0000_0000, "ctrl_sel1"};
      vecs[3] = '{ADR_CTRL,    32'h0000_0A05, 4'h3, 32'h0000_0A05, "ctrl_sel01"};
      vecs[4] = '{ADR_STRETCH, 32'h1234_ABCD, 4'hF, 32'h0000_ABCD, "stretch_all"};
      vecs[5] = '{ADR_STRETCH, 32'h0000_FF00, 4'h1, 32'h0000_AB00, "stretch_sel0"};
      vecs[6] = '{ADR_STRETCH, 32'h0000_3400, 4'h2, 32'h0000_3400, "stretch_sel1"};
      vecs[7] = '{ADR_STATUS,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000, "status_w1c"};
      vecs[8] = '{ADR_COUNT,   32'hFFFF_FFFF, 4'hF, 32'h0000_0000, "count_clr"};
      vecs[9] = '{ADR_CTRL,    32'h0000_0000, 4'hF, 32'h0000_0000, "ctrl_zero"};

      // Reset with every wake line already high.
      wb_idle();
      wake = 4'hF;
      repeat (3) tick();
      check("rst_pad", 32'(wake_pad), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
      check("rst_dat", bus.wbs_dat_o, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      tick();
      wb_write(ADR_CTRL, 32'h0000_0F01, 4'hF);
      repeat (3) tick();
      check("steady_high_pad", 32'(wake_pad), 32'd0);
      expect_read(ADR_COUNT, 32'd0, "steady_high_count");
      expect_read(ADR_STATUS, 32'd0, "steady_high_status");
      wake = '0;
      wb_write(ADR_CTRL, 32'h0, 4'hF);
      expect_read(ADR_STRETCH, 32'd0, "rst_stretch");

      for (int i = 0; i < 10; i++) begin
         wb_write(vecs[i].idx, vecs[i].wdata, vecs[i].sel);
         expect_read(vecs[i].idx, vecs[i].exp_rd, vecs[i].name);
      end

      // Single stretched pulse.
      wb_write(ADR_CTRL, 32'h0000_0101, 4'hF);
      wb_write(ADR_STRETCH, 32'd3, 4'hF);
      check("pad_before_pulse", 32'(wake_pad), 32'd0);
      pulse_run(4'h1, 0, -1, 6, 1, 4, "pad_single");
      expect_read(ADR_STATUS, 32'h1, "single_status");
      expect_read(ADR_COUNT, 32'd1, "single_count");

      // Retrigger three cycles after the first edge.
      wb_write(ADR_COUNT, 32'h0, 4'hF);
      wb_write(ADR_STATUS, 32'h1, 4'hF);
      wb_write(ADR_STRETCH, 32'd5, 4'hF);
      pulse_run(4'h1, 0, 3, 12, 1, 9, "pad_retrigger");
      expect_read(ADR_COUNT, 32'd2, "retrigger_count");

      // VAD gating on channel 1.
      wb_write(ADR_STATUS, 32'hF, 4'hF);
      wb_write(ADR_CTRL, 32'h0000_0305, 4'hF);
      wb_write(ADR_STRETCH, 32'd2, 4'hF);
      pulse_run(4'h2, 0, -1, 5, 1, 0, "pad_vad_blocked");
      expect_read(ADR_STATUS, 32'h0, "vad_blocked_status");
      vad_pad = 1'b1;
      repeat (3) tick();
      pulse_run(4'h2, 0, -1, 5, 1, 3, "pad_vad_open");
      expect_read(ADR_STATUS, 32'h2, "vad_open_status");
      vad_pad = 1'b0;

      // Interrupt and W1C on channel 2.
      wb_write(ADR_STATUS, 32'hF, 4'hF);
      wb_write(ADR_CTRL, 32'h0000_0403, 4'hF);
      tick();
      check("irq_idle", 32'(irq), 32'd0);
      pulse_run(4'h4, 0, -1, 5, 1, 3, "pad_ch2");
      check("irq_set", 32'(irq), 32'd1);
      wb_write(ADR_STATUS, 32'h4, 4'hF);
      tick();
      check("irq_cleared", 32'(irq), 32'd0);
      expect_read(ADR_STATUS, 32'h0, "status_cleared");
      begin
         logic [31:0] junk;
         wb_xfer(1'b1, ADR_STATUS, 32'h4, 4'hF, 4'h4, junk);
      end
      expect_read(ADR_STATUS, 32'h4, "status_set_wins");

      // Counter saturation and clear.
      wb_write(ADR_CTRL, 32'h0000_0101, 4'hF);
      wb_write(ADR_STRETCH, 32'd0, 4'hF);
      wb_write(ADR_COUNT, 32'h0, 4'hF);
      for (int i = 0; i < 20; i++) begin
         wake = 4'h1;
         tick();
         wake = 4'h0;
         tick();
      end
      expect_read(ADR_COUNT, 32'd15, "count_saturate");
      wb_write(ADR_COUNT, 32'h0, 4'hF);
      expect_read(ADR_COUNT, 32'd0, "count_write_clear");
      begin
         logic [31:0] junk;
         wb_xfer(1'b1, ADR_COUNT, 32'h0, 4'hF, 4'h1, junk);
      end
      expect_read(ADR_COUNT, 32'd1, "count_clear_and_event");

      // Reset arriving mid-HOLD and mid-transaction.
      wb_write(ADR_CTRL, 32'h0000_0103, 4'hF);
      wb_write(ADR_STRETCH, 32'd10, 4'hF);
      wake = 4'h1;
      tick();
      wake = 4'h0;
      tick();
      check("hold_pad", 32'(wake_pad), 32'd1);
      check("hold_state", 32'(dbg_state), 32'(ST_HOLD));
      check("hold_irq", 32'(irq), 32'd1);
      rst = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_cyc_i = 1'b1;
      tick();
      check("midrst_pad", 32'(wake_pad), 32'd0);
      check("midrst_irq", 32'(irq), 32'd0);
      check("midrst_ack", 32'(bus.wbs_ack_o), 32'd0);
      check("midrst_dat", bus.wbs_dat_o, 32'd0);
      check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
      wb_idle();
      rst = 1'b0;
      tick();
      expect_read(ADR_CTRL, 32'd0, "post_rst_ctrl");
      expect_read(ADR_STRETCH, 32'd0, "post_rst_stretch");
      expect_read(ADR_STATUS, 32'd0, "post_rst_status");
      expect_read(ADR_COUNT, 32'd0, "post_rst_count");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
